// File: rtl/lcv_div_iter_del.sv
// lcv_div_iter_del
// Iterative radix-2 restoring divider. Produces the quotient and remainder of a
// WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned. The core
// resolves one quotient bit per clock. Latency is constant: outp_valid rises
// WIDTH+2 edges after the accept edge, whatever the operands.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   inp_valid         operands valid
//   inp_ready         divider idle and able to accept operands
//   inp_a             dividend
//   inp_b             divisor
//   inp_signed        1 = two's-complement operation, 0 = unsigned
//   outp_valid        result valid
//   outp_ready        consumer accepts result
//   outp_quot         quotient (truncated toward zero)
//   outp_rem          remainder (takes the sign of the dividend)
//   outp_div_by_zero  divisor was zero; meaningful only while outp_valid
//
// state | meaning
// IDLE  | waiting for operands, inp_ready high
// BUSY  | one restoring subtract/shift step per cycle, WIDTH steps
// FIXUP | apply result signs / divide-by-zero override, register outputs
// DONE  | result presented, held until outp_ready

module lcv_div_iter_del #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             inp_signed,
    output logic             outp_valid,
    input  logic             outp_ready,
    output logic [WIDTH-1:0] outp_quot,
    output logic [WIDTH-1:0] outp_rem,
    output logic             outp_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;      // holds the dividend, shifted out as quotient bits shift in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_a_raw;     // untouched dividend, returned as remainder on divide by zero
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;

    logic             r_valid;
    logic [WIDTH-1:0] r_outp_quot;
    logic [WIDTH-1:0] r_outp_rem;
    logic             r_outp_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;

    assign inp_ready        = (r_state == IDLE);
    assign w_accept         = inp_valid && (r_state == IDLE);
    assign w_last           = (r_count == CW'(WIDTH - 1));

    // Magnitudes use wraparound negation, so the most-negative value maps onto
    // itself. Read as unsigned, that is the correct magnitude. This gives the
    // min / -1 overflow result with no special case.
    assign w_a_neg          = inp_signed & inp_a[WIDTH-1];
    assign w_b_neg          = inp_signed & inp_b[WIDTH-1];
    assign w_a_mag          = w_a_neg ? (-inp_a) : inp_a;
    assign w_b_mag          = w_b_neg ? (-inp_b) : inp_b;

    // The partial remainder is always below the divisor. The shifted value
    // therefore fits in WIDTH+1 bits, and a set MSB on the trial marks it negative.
    assign w_rem_sh         = {r_rem, r_quot[WIDTH-1]};
    assign w_trial          = w_rem_sh - {1'b0, r_divisor};

    assign outp_valid       = r_valid;
    assign outp_quot        = r_outp_quot;
    assign outp_rem         = r_outp_rem;
    assign outp_div_by_zero = r_outp_dbz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = BUSY;
            BUSY:    if (w_last)     w_state_nxt = FIXUP;
            FIXUP:                   w_state_nxt = DONE;
            DONE:    if (outp_ready) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_divisor   <= '0;
            r_a_raw     <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_valid     <= 1'b0;
            r_outp_quot <= '0;
            r_outp_rem  <= '0;
            r_outp_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_quot    <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_a_raw   <= inp_a;
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_sign_q  <= w_a_neg ^ w_b_neg;
                        r_sign_r  <= w_a_neg;
                        r_dbz     <= (inp_b == '0);
                    end
                end
                BUSY: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                    end
                    r_quot  <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_count <= r_count + 1'b1;
                end
                FIXUP: begin
                    // Divide by zero overrides the sign fixup entirely.
                    if (r_dbz) begin
                        r_outp_quot <= '1;
                        r_outp_rem  <= r_a_raw;
                    end else begin
                        r_outp_quot <= r_sign_q ? (-r_quot) : r_quot;
                        r_outp_rem  <= r_sign_r ? (-r_rem)  : r_rem;
                    end
                    r_outp_dbz <= r_dbz;
                    r_valid    <= 1'b1;
                end
                DONE: begin
                    if (outp_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcv_div_iter_del.sv
module tb_lcv_div_iter_del;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         inp_valid;
    logic         inp_ready;
    logic [W-1:0] inp_a;
    logic [W-1:0] inp_b;
    logic         inp_signed;
    logic         outp_valid;
    logic         outp_ready;
    logic [W-1:0] outp_quot;
    logic [W-1:0] outp_rem;
    logic         outp_div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    lcv_div_iter_del #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .inp_valid        (inp_valid),
        .inp_ready        (inp_ready),
        .inp_a            (inp_a),
        .inp_b            (inp_b),
        .inp_signed       (inp_signed),
        .outp_valid       (outp_valid),
        .outp_ready       (outp_ready),
        .outp_quot        (outp_quot),
        .outp_rem         (outp_rem),
        .outp_div_by_zero (outp_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain 64-bit arithmetic. SV signed division truncates toward
    // zero, and % takes the dividend's sign. min/-1 yields 2^(W-1), which
    // truncates to the most-negative value.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            if (s) begin
                sa = {{(64-W){a[W-1]}}, a};
                sb = {{(64-W){b[W-1]}}, b};
            end else begin
                sa = {{(64-W){1'b0}}, a};
                sb = {{(64-W){1'b0}}, b};
            end
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           edges;
        model(a, b, s, eq, er, ez);
        @(negedge clk);
        chk({tag, ".ready_idle"}, 64'(inp_ready), 64'd1);
        inp_a      = a;
        inp_b      = b;
        inp_signed = s;
        inp_valid  = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        inp_valid  = 1'b0;
        // Operand changes after the accept edge must be ignored.
        inp_a      = $urandom;
        inp_b      = $urandom;
        inp_signed = ~s;
        chk({tag, ".ready_busy"}, 64'(inp_ready), 64'd0);
        while (!outp_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(edges), 64'(W + 2));
        chk({tag, ".quot"}, 64'(outp_quot), 64'(eq));
        chk({tag, ".rem"}, 64'(outp_rem), 64'(er));
        chk({tag, ".dbz"}, 64'(outp_div_by_zero), 64'(ez));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(outp_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(inp_ready), 64'd0);
            chk({tag, ".hold_quot"}, 64'(outp_quot), 64'(eq));
            chk({tag, ".hold_rem"}, 64'(outp_rem), 64'(er));
        end
        outp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outp_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(outp_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(inp_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        rst        = 1'b0;
        inp_valid  = 1'b0;
        inp_a      = '0;
        inp_b      = '0;
        inp_signed = 1'b0;
        outp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 64'(outp_valid), 64'd0);
        chk("rst.ready", 64'(inp_ready), 64'd1);
        chk("rst.quot", 64'(outp_quot), 64'd0);
        chk("rst.rem", 64'(outp_rem), 64'd0);
        chk("rst.dbz", 64'(outp_div_by_zero), 64'd0);
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s-7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s7_-2");
        run_op(32'd5, 32'd0, 1'b0, 0, "u5_0");
        run_op(32'd5, 32'd0, 1'b1, 0, "s5_0");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, "s-5_0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "uffff_1");
        run_op(32'd12345, 32'd678, 1'b0, 10, "backpr");

        // Reset during BUSY iteration 10, then a clean op.
        @(negedge clk);
        inp_a      = 32'd1000;
        inp_b      = 32'd3;
        inp_signed = 1'b0;
        inp_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inp_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.valid", 64'(outp_valid), 64'd0);
        chk("midrst.ready", 64'(inp_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ready_rel", 64'(inp_ready), 64'd1);
        chk("midrst.valid_rel", 64'(outp_valid), 64'd0);
        run_op(32'd9, 32'd3, 1'b0, 0, "post_rst");

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                4: rb = rb >> $urandom_range(8, 28);
                default: ;
            endcase
            run_op(ra, rb, rs, (k % 5 == 0) ? 2 : 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcv_div_iter_del.md
Name: lcv_div_iter_del

Overview:
- Iterative radix-2 integer divider; the inverse of the team's multiply-accumulate and add/sub DSP helpers.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned, one quotient bit per clock.
- Valid/ready on both sides. Sits beside the MAC units in the execute datapath and serves divide/remainder ops that cannot map to DSP48 slices.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- inp_valid  input  1  operands valid.
- inp_ready  output  1  divider can accept operands.
- inp_a  input  WIDTH  dividend.
- inp_b  input  WIDTH  divisor.
- inp_signed  input  1  1 = two's-complement signed op, 0 = unsigned.
- outp_valid  output  1  result valid.
- outp_ready  input  1  consumer accepts result.
- outp_quot  output  WIDTH  quotient.
- outp_rem  output  WIDTH  remainder.
- outp_div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset (rst low, async): state IDLE, iteration counter 0, outp_valid 0, outp_quot 0, outp_rem 0, outp_div_by_zero 0, internal regs 0. inp_ready reads 1 once in IDLE.
- inp_ready = (state == IDLE), combinational from state only. Never depends on inp_valid.
- States:
  - IDLE: on inp_valid && inp_ready, latch |a|, |b| (magnitudes when inp_signed, else raw), sign_q = a_neg ^ b_neg, sign_r = a_neg, dbz = (inp_b == 0). Clear the partial remainder and set count = 0. Go to BUSY.
  - BUSY: one restoring step per cycle.
    - Shift {rem, quot} left by 1, bringing in the dividend MSB.
    - trial = rem_shifted - |b| at WIDTH+1 bits.
    - If trial is non-negative: rem = trial, quotient LSB = 1. Otherwise keep rem_shifted, quotient LSB = 0.
    - count increments; after the WIDTH-th step go to FIXUP.
  - FIXUP: apply signs and register the outputs.
    - quot = sign_q ? -q : q.
    - rem = sign_r ? -r : r.
    - Set outp_valid = 1 and go to DONE.
  - DONE: outputs held stable while outp_valid && !outp_ready. On outp_valid && outp_ready, outp_valid drops to 0 on the next edge and state goes to IDLE. No new operand is accepted in the same cycle.
- Latency: constant. outp_valid rises WIDTH+2 edges after the accept edge (1 accept + WIDTH iterations + 1 fixup), for every operand class.
- Throughput: one op per WIDTH+3 cycles minimum.
- Divide by zero: outp_quot = all ones, outp_rem = inp_a unmodified, outp_div_by_zero = 1. Applies to both signed and unsigned ops and overrides the sign fixup. Full latency still applies.
- Signed overflow (inp_signed, a = most-negative, b = -1): outp_quot = most-negative, outp_rem = 0, outp_div_by_zero = 0. This falls out naturally when magnitudes use WIDTH-bit unsigned arithmetic with wraparound negation.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend; a == quot*b + rem always holds mod 2^WIDTH.
- Operands are sampled only at the accept edge. inp_a, inp_b and inp_signed changes during BUSY have no effect.
- Reset asserted mid-operation: immediate return to the reset values above; any in-flight result is discarded.
- outp_div_by_zero is valid only while outp_valid = 1.

Test Plan:
- Unsigned 100 / 7 -> outp_valid after 34 edges; quot = 14, rem = 2, dbz = 0.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> quot = 0xFFFFFFFD (-3), rem = 0xFFFFFFFF (-1). Signed 7 / -2 -> quot = -3, rem = 1.
- Divide by zero, unsigned and signed 5 / 0 and signed -5 / 0 -> quot = 0xFFFFFFFF, rem = inp_a, dbz = 1, same 34-edge latency.
- Signed 0x80000000 / 0xFFFFFFFF -> quot = 0x80000000, rem = 0. Unsigned 0xFFFFFFFF / 1 -> quot = 0xFFFFFFFF, rem = 0.
- Backpressure: hold outp_ready = 0 for 10 cycles after outp_valid -> outputs stable, inp_ready = 0. Pulse outp_ready -> outp_valid falls next edge, inp_ready = 1. Back-to-back ops spaced at WIDTH+3 cycles all return correct results.
- Drive rst low at BUSY iteration 10 -> outp_valid = 0 and inp_ready = 1 after release. A new op 9 / 3 then returns quot = 3, rem = 0 with no residue from the aborted op.
